// File: rtl/cluster_tcdm_bank_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cluster_tcdm_bank_arb                                        |
// | Description : N_IN initiators onto N_BANK word-interleaved TCDM banks.     |
// |               Each bank has its own combinational two-class arbiter.       |
// |               The high class has precedence, and each class is served      |
// |               round-robin. A per-bank starvation counter lets the low      |
// |               class win once max_stall_i is reached. Grants return in the  |
// |               same cycle. Responses follow one cycle after the grant.      |
// | Ports       : clk_i, rst_i (sync, active-high)                             |
// |               req_i/add_i/wen_i/data_i/be_i/prio_i : initiator requests    |
// |               max_stall_i : low-class starvation threshold (0 = off)       |
// |               gnt_o/r_valid_o/r_data_o              : initiator responses  |
// |               bank_req_o/add/wen/data/be, bank_rdata_i : bank side         |
// | Options     : `define TCDM_ARB_PERF_CNT_EN adds perf_clr_i and the         |
// |               per-initiator 32-bit stall counters on stall_cnt_o.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cluster_tcdm_bank_arb #(
  parameter int N_IN    = 16,
  parameter int N_BANK  = 16,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BANK_AW = 11
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_IN-1:0]             req_i,
  input  logic [N_IN*AW-1:0]          add_i,
  input  logic [N_IN-1:0]             wen_i,
  input  logic [N_IN*DW-1:0]          data_i,
  input  logic [N_IN*(DW/8)-1:0]      be_i,
  input  logic [N_IN-1:0]             prio_i,
  input  logic [7:0]                  max_stall_i,
  output logic [N_IN-1:0]             gnt_o,
  output logic [N_IN-1:0]             r_valid_o,
  output logic [N_IN*DW-1:0]          r_data_o,
  output logic [N_BANK-1:0]           bank_req_o,
  output logic [N_BANK*BANK_AW-1:0]   bank_add_o,
  output logic [N_BANK-1:0]           bank_wen_o,
  output logic [N_BANK*DW-1:0]        bank_data_o,
  output logic [N_BANK*(DW/8)-1:0]    bank_be_o,
  input  logic [N_BANK*DW-1:0]        bank_rdata_i
`ifdef TCDM_ARB_PERF_CNT_EN
  ,
  input  logic                        perf_clr_i,
  output logic [N_IN*32-1:0]          stall_cnt_o
`endif
);

  localparam int BW   = DW / 8;
  localparam int OFS  = $clog2(BW);
  localparam int BSEL = $clog2(N_BANK);
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;

  // Round-robin search starting at ptr. Returns {found, index}. The loop walks
  // backwards so that the candidate nearest to ptr is the last one written.
  function automatic logic [IW:0] rr_pick(input logic [N_IN-1:0] hits,
                                          input logic [IW-1:0]   ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (hits[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  logic [BSEL-1:0]    tgt      [N_IN];
  logic [BANK_AW-1:0] wadd     [N_IN];
  logic [IW-1:0]      win      [N_BANK];
  logic [IW-1:0]      rsp_win  [N_BANK];
  logic [N_BANK-1:0]  bank_any;
  logic [N_BANK-1:0]  bank_rv;
  logic [N_BANK-1:0]  bank_rd;

  for (genvar i = 0; i < N_IN; i++) begin : g_dec
    assign tgt[i]  = add_i[i*AW + OFS +: BSEL];
    assign wadd[i] = add_i[i*AW + OFS + BSEL +: BANK_AW];
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [N_IN-1:0]    hit_hi, hit_lo;
    logic               found_hi, found_lo, flip, sel_lo, any;
    logic [IW-1:0]      pick_hi, pick_lo, w, w_nxt;
    logic [IW-1:0]      ptr_hi_q, ptr_lo_q, rwin_q;
    logic [7:0]         stall_q;
    logic               rv_q, rrd_q;

    always_comb begin
      hit_hi = '0;
      hit_lo = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (req_i[i] && (tgt[i] == BSEL'(b))) begin
          if (prio_i[i]) hit_hi[i] = 1'b1;
          else           hit_lo[i] = 1'b1;
        end
      end
    end

    assign {found_hi, pick_hi} = rr_pick(hit_hi, ptr_hi_q);
    assign {found_lo, pick_lo} = rr_pick(hit_lo, ptr_lo_q);

    // Starved low class takes precedence until it is served once.
    assign flip   = (max_stall_i != 8'd0) && (stall_q >= max_stall_i);
    assign sel_lo = found_lo && (flip || !found_hi);
    assign any    = (found_hi || found_lo) && !rst_i;
    assign w      = sel_lo ? pick_lo : pick_hi;
    assign w_nxt  = (w == IW'(N_IN - 1)) ? '0 : w + IW'(1);

    assign win[b]      = w;
    assign bank_any[b] = any;
    assign bank_rv[b]  = rv_q;
    assign bank_rd[b]  = rrd_q;
    assign rsp_win[b]  = rwin_q;

    assign bank_req_o[b]                    = any;
    assign bank_wen_o[b]                    = any ? wen_i[w] : 1'b0;
    assign bank_add_o[b*BANK_AW +: BANK_AW] = any ? wadd[w] : '0;
    assign bank_data_o[b*DW +: DW]          = any ? data_i[int'(w)*DW +: DW] : '0;
    assign bank_be_o[b*BW +: BW]            = any ? be_i[int'(w)*BW +: BW] : '0;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ptr_hi_q <= '0;
        ptr_lo_q <= '0;
        stall_q  <= '0;
        rv_q     <= 1'b0;
        rrd_q    <= 1'b0;
        rwin_q   <= '0;
      end else begin
        if (any) begin
          if (sel_lo) ptr_lo_q <= w_nxt;
          else        ptr_hi_q <= w_nxt;
        end
        if (any && sel_lo)
          stall_q <= '0;
        else if ((|hit_lo) && (stall_q != 8'hFF))
          stall_q <= stall_q + 8'd1;
        rv_q   <= any;
        rrd_q  <= any && wen_i[w];
        rwin_q <= w;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N_IN; i++)
      if (req_i[i] && bank_any[tgt[i]] && (win[tgt[i]] == IW'(i)))
        gnt_o[i] = 1'b1;
  end

  // Gated by rst_i so that a response in flight when reset arrives is dropped.
  always_comb begin
    r_valid_o = '0;
    r_data_o  = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (bank_rv[b] && !rst_i) begin
        r_valid_o[rsp_win[b]] = 1'b1;
        if (bank_rd[b])
          r_data_o[int'(rsp_win[b])*DW +: DW] = bank_rdata_i[b*DW +: DW];
      end
    end
  end

`ifdef TCDM_ARB_PERF_CNT_EN
  for (genvar i = 0; i < N_IN; i++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i || perf_clr_i)
        cnt_q <= '0;
      else if (req_i[i] && !gnt_o[i] && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
    end
    assign stall_cnt_o[i*32 +: 32] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: doc/cluster_tcdm_bank_arb.md
CLUSTER_TCDM_BANK_ARB -- requirements
Module: cluster_tcdm_bank_arb

Interface
REQ-001 SHALL have parameter N_IN, default 16: number of initiator channels, 1..32.
REQ-002 SHALL have parameter N_BANK, default 16: number of TCDM banks, power of two, 2..64.
REQ-003 SHALL have parameter AW, default 32: initiator address width.
REQ-004 SHALL have parameter DW, default 32: data width, multiple of 8; BW = DW/8.
REQ-005 SHALL have parameter BANK_AW, default 11: bank word-address width.
REQ-006 SHALL have the following ports, one per line, in the order given:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  N_IN  per-initiator request.
- add_i  in  N_IN*AW  byte address.
- wen_i  in  N_IN  1 = read, 0 = write.
- data_i  in  N_IN*DW  write data.
- be_i  in  N_IN*BW  byte enables.
- prio_i  in  N_IN  1 = high-priority class (e.g. HWPE), 0 = low (cores/DMA).
- max_stall_i  in  8  low-class starvation threshold; 0 disables override.
- gnt_o  out  N_IN  grant, same cycle as request.
- r_valid_o  out  N_IN  response strobe.
- r_data_o  out  N_IN*DW  read data.
- bank_req_o  out  N_BANK  bank request.
- bank_add_o  out  N_BANK*BANK_AW  bank word address.
- bank_wen_o  out  N_BANK  1 = read.
- bank_data_o  out  N_BANK*DW  bank write data.
- bank_be_o  out  N_BANK*BW  bank byte enables.
- bank_rdata_i  in  N_BANK*DW  bank read data, valid one cycle after bank_req_o.

Function
REQ-007 SHALL decode the target bank as add_i[OFS +: log2(N_BANK)], with OFS = log2(BW).
REQ-008 SHALL drive the bank word address as add_i[OFS+log2(N_BANK) +: BANK_AW].
REQ-009 SHALL arbitrate each bank independently and combinationally, granting at most one initiator per bank per cycle.
REQ-010 SHALL normally give the high class strict precedence over the low class.
REQ-011 SHALL invert class precedence for a bank when its stall counter >= max_stall_i and max_stall_i != 0; the low class then wins that bank for one grant.
REQ-012 SHALL arbitrate within a class round-robin, using a per-bank, per-class pointer.
REQ-013 SHALL, on each grant, register that bank/class pointer to winner index + 1, wrapping N_IN-1 -> 0.
REQ-014 SHALL hold the pointer when the bank has no grant.
REQ-015 SHALL maintain a per-bank 8-bit stall counter:
- +1 in any cycle where a low-class request targets the bank and is not granted;
- cleared on any low-class grant to that bank;
- saturates at 255.
REQ-016 SHALL drive gnt_o[i] = 1 only when req_i[i] = 1 and initiator i won its bank.
REQ-017 SHALL drive bank_req_o low and the bank data/addr/be outputs to 0 for a bank with no requester.
REQ-018 SHALL register the winner index and a valid flag per bank.
REQ-019 SHALL, exactly one cycle after a grant, pulse r_valid_o[i] for both reads and writes.
REQ-020 SHALL drive r_data_o[i] with bank_rdata_i of the registered bank for reads, and 0 for writes.
REQ-021 SHALL keep back-to-back grants to one initiator pipelined: one response per cycle, no bubbles.
REQ-022 SHALL process each initiator's simultaneous requests to different banks independently.

Reset
REQ-023 SHALL, while rst_i = 1 at a clock edge, clear all pointers, stall counters and response registers.
REQ-024 SHALL, in the cycle after reset, hold r_valid_o = 0 and r_data_o = 0.
REQ-025 SHALL force gnt_o = 0 and bank_req_o = 0 combinationally while rst_i = 1.
REQ-026 SHALL, when reset is asserted mid-transaction, drop the pending response (no r_valid_o).

Configuration
REQ-027 SHALL, with macro TCDM_ARB_PERF_CNT_EN defined, add the following:
- input perf_clr_i (1);
- output stall_cnt_o (N_IN*32): per-initiator 32-bit counters, +1 per cycle req_i = 1 and gnt_o = 0, saturating, cleared by perf_clr_i or rst_i (clear wins over increment).
REQ-028 SHALL, without TCDM_ARB_PERF_CNT_EN, have no perf ports or counter logic, with identical arbitration behaviour.

Verification
REQ-029 SHALL cover: initiators 0 and 1, low class, both reading bank 3 continuously -> grants alternate 0,1,0,1; each r_valid_o one cycle after its gnt_o.
REQ-030 SHALL cover: initiator 2 high class and initiator 0 low class on bank 5, max_stall_i = 4 -> initiator 2 granted 4 cycles, initiator 0 granted the 5th cycle, counter back to 0.
REQ-031 SHALL cover: max_stall_i = 0 with the same stimulus -> initiator 0 never granted; stall counter saturates at 255.
REQ-032 SHALL cover: N_IN = N_BANK = 16, initiator i addressing bank i -> all 16 granted every cycle, zero stalls.
REQ-033 SHALL cover: write to bank 7 addr 0x10 data 0xDEADBEEF be 0xF, then read -> bank write fields exact; read returns 0xDEADBEEF on r_data_o one cycle after gnt_o.
REQ-034 SHALL cover: rst_i asserted the cycle after a grant -> no r_valid_o; pointers restart at index 0; perf counters (if enabled) read 0.
